// File: rtl/ctrl_pkg.sv
// Shared control-bundle layout, bubble constant, ALUOp and forward-select codes
// for the in-order pipeline control path.
package ctrl_pkg;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Invalid slots collapse to a bubble; MemtoReg is meaningless without a register write.
   function automatic ctrl_t capture_ctrl(
      input logic       valid,
      input logic       branch,
      input logic       mem_read,
      input logic       mem_to_reg,
      input logic       mem_write,
      input logic       alu_src,
      input logic       reg_write,
      input logic [1:0] alu_op
   );
      ctrl_t c;
      c = CTRL_BUBBLE;
      if (valid) begin
         c.branch     = branch;
         c.mem_read   = mem_read;
         c.mem_to_reg = mem_to_reg & reg_write;
         c.mem_write  = mem_write;
         c.alu_src    = alu_src;
         c.reg_write  = reg_write;
         c.alu_op     = alu_op;
      end
      return c;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use stall, taken-branch flush and ALU operand forward decode.
// Zero latency; all outputs forced low while reset is asserted.
module hazard_unit
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
)
(
   input  logic             i_reset_n,
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_ex_valid,
   input  logic             i_ex_mem_read,
   input  logic             i_ex_branch,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic [REG_W-1:0] i_ex_rs1,
   input  logic [REG_W-1:0] i_ex_rs2,
   input  logic             i_branch_taken,
   input  logic             i_mem_valid,
   input  logic             i_mem_reg_write,
   input  logic [REG_W-1:0] i_mem_rd,
   input  logic             i_wb_valid,
   input  logic             i_wb_reg_write,
   input  logic [REG_W-1:0] i_wb_rd,
   output logic             o_stall,
   output logic             o_flush,
   output logic [1:0]       o_forward_a,
   output logic [1:0]       o_forward_b
);

   logic w_load_use;
   logic w_mem_wr;
   logic w_wb_wr;

   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                          input logic mem_wr, input logic [REG_W-1:0] mem_rd,
                                          input logic wb_wr,  input logic [REG_W-1:0] wb_rd);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_wr && mem_rd == rs)
         sel = FWD_MEM;
      else if (wb_wr && wb_rd == rs)
         sel = FWD_WB;
      return sel;
   endfunction

   assign w_load_use = i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                       ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

   // A taken branch discards the ID instruction, so its load-use hazard is moot.
   assign o_flush = i_reset_n && i_ex_valid && i_ex_branch && i_branch_taken;
   assign o_stall = i_reset_n && w_load_use && !o_flush;

   assign w_mem_wr = i_reset_n && i_mem_valid && i_mem_reg_write && (i_mem_rd != '0);
   assign w_wb_wr  = i_reset_n && i_wb_valid  && i_wb_reg_write  && (i_wb_rd  != '0);

   assign o_forward_a = fwd_sel(i_ex_rs1, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);
   assign o_forward_b = fwd_sel(i_ex_rs2, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);

endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control stage registers with hazard decode; ID->WB latency 3 cycles.
// Load-use stalls and taken-branch flushes insert one EX bubble while MEM/WB keep advancing.
module control_pipeline
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic             id_Branch,
   input  logic             id_MemRead,
   input  logic             id_MemtoReg,
   input  logic             id_MemWrite,
   input  logic             id_ALUSrc,
   input  logic             id_RegWrite,
   input  logic [1:0]       id_ALUOp,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic             ex_valid,
   output logic             ex_Branch,
   output logic             ex_MemRead,
   output logic             ex_MemtoReg,
   output logic             ex_MemWrite,
   output logic             ex_ALUSrc,
   output logic             ex_RegWrite,
   output logic [1:0]       ex_ALUOp,
   output logic [REG_W-1:0] ex_rd,
   output logic [REG_W-1:0] ex_rs1,
   output logic [REG_W-1:0] ex_rs2,
   output logic             mem_valid,
   output logic             mem_Branch,
   output logic             mem_MemRead,
   output logic             mem_MemtoReg,
   output logic             mem_MemWrite,
   output logic             mem_ALUSrc,
   output logic             mem_RegWrite,
   output logic [1:0]       mem_ALUOp,
   output logic [REG_W-1:0] mem_rd,
   output logic             wb_valid,
   output logic             wb_Branch,
   output logic             wb_MemRead,
   output logic             wb_MemtoReg,
   output logic             wb_MemWrite,
   output logic             wb_ALUSrc,
   output logic             wb_RegWrite,
   output logic [1:0]       wb_ALUOp,
   output logic [REG_W-1:0] wb_rd,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b
);

   ctrl_t            r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
   logic             r_ex_vld, r_mem_vld, r_wb_vld;
   logic [REG_W-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2, r_mem_rd, r_wb_rd;

   ctrl_t            w_id_ctrl;
   logic             w_stall, w_flush;

   assign w_id_ctrl = capture_ctrl(id_valid, id_Branch, id_MemRead, id_MemtoReg,
                                   id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp);

   hazard_unit #(.REG_W(REG_W)) u_hazard (
      .i_reset_n       (reset_n),
      .i_id_valid      (id_valid),
      .i_id_rs1        (id_rs1),
      .i_id_rs2        (id_rs2),
      .i_ex_valid      (r_ex_vld),
      .i_ex_mem_read   (r_ex_ctrl.mem_read),
      .i_ex_branch     (r_ex_ctrl.branch),
      .i_ex_rd         (r_ex_rd),
      .i_ex_rs1        (r_ex_rs1),
      .i_ex_rs2        (r_ex_rs2),
      .i_branch_taken  (ex_branch_taken),
      .i_mem_valid     (r_mem_vld),
      .i_mem_reg_write (r_mem_ctrl.reg_write),
      .i_mem_rd        (r_mem_rd),
      .i_wb_valid      (r_wb_vld),
      .i_wb_reg_write  (r_wb_ctrl.reg_write),
      .i_wb_rd         (r_wb_rd),
      .o_stall         (w_stall),
      .o_flush         (w_flush),
      .o_forward_a     (forward_a),
      .o_forward_b     (forward_b)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ex_vld   <= 1'b0;
         r_ex_ctrl  <= CTRL_BUBBLE;
         r_ex_rd    <= '0;
         r_ex_rs1   <= '0;
         r_ex_rs2   <= '0;
         r_mem_vld  <= 1'b0;
         r_mem_ctrl <= CTRL_BUBBLE;
         r_mem_rd   <= '0;
         r_wb_vld   <= 1'b0;
         r_wb_ctrl  <= CTRL_BUBBLE;
         r_wb_rd    <= '0;
      end else begin
         if (w_stall || w_flush || !id_valid) begin
            r_ex_vld  <= 1'b0;
            r_ex_ctrl <= CTRL_BUBBLE;
            r_ex_rd   <= '0;
            r_ex_rs1  <= '0;
            r_ex_rs2  <= '0;
         end else begin
            r_ex_vld  <= 1'b1;
            r_ex_ctrl <= w_id_ctrl;
            r_ex_rd   <= id_rd;
            r_ex_rs1  <= id_rs1;
            r_ex_rs2  <= id_rs2;
         end
         r_mem_vld  <= r_ex_vld;
         r_mem_ctrl <= r_ex_ctrl;
         r_mem_rd   <= r_ex_rd;
         r_wb_vld   <= r_mem_vld;
         r_wb_ctrl  <= r_mem_ctrl;
         r_wb_rd    <= r_mem_rd;
      end
   end

   assign stall = w_stall;
   assign flush = w_flush;

   assign ex_valid    = r_ex_vld;
   assign ex_Branch   = r_ex_ctrl.branch;
   assign ex_MemRead  = r_ex_ctrl.mem_read;
   assign ex_MemtoReg = r_ex_ctrl.mem_to_reg;
   assign ex_MemWrite = r_ex_ctrl.mem_write;
   assign ex_ALUSrc   = r_ex_ctrl.alu_src;
   assign ex_RegWrite = r_ex_ctrl.reg_write;
   assign ex_ALUOp    = r_ex_ctrl.alu_op;
   assign ex_rd       = r_ex_rd;
   assign ex_rs1      = r_ex_rs1;
   assign ex_rs2      = r_ex_rs2;

   assign mem_valid    = r_mem_vld;
   assign mem_Branch   = r_mem_ctrl.branch;
   assign mem_MemRead  = r_mem_ctrl.mem_read;
   assign mem_MemtoReg = r_mem_ctrl.mem_to_reg;
   assign mem_MemWrite = r_mem_ctrl.mem_write;
   assign mem_ALUSrc   = r_mem_ctrl.alu_src;
   assign mem_RegWrite = r_mem_ctrl.reg_write;
   assign mem_ALUOp    = r_mem_ctrl.alu_op;
   assign mem_rd       = r_mem_rd;

   assign wb_valid    = r_wb_vld;
   assign wb_Branch   = r_wb_ctrl.branch;
   assign wb_MemRead  = r_wb_ctrl.mem_read;
   assign wb_MemtoReg = r_wb_ctrl.mem_to_reg;
   assign wb_MemWrite = r_wb_ctrl.mem_write;
   assign wb_ALUSrc   = r_wb_ctrl.alu_src;
   assign wb_RegWrite = r_wb_ctrl.reg_write;
   assign wb_ALUOp    = r_wb_ctrl.alu_op;
   assign wb_rd       = r_wb_rd;

endmodule

// File: tb/tb_control_pipeline.sv
// Randomized plus directed bench for control_pipeline against a history-based behavioural model.
module tb_control_pipeline;

   typedef struct packed {
      logic       v, br, mr, m2r, mw, as, rw;
      logic [1:0] op;
      logic [4:0] rd, rs1, rs2;
   } ins_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       id_valid, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
   logic [1:0] id_ALUOp;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_branch_taken;
   logic       stall, flush;
   logic       ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
   logic [1:0] ex_ALUOp;
   logic [4:0] ex_rd, ex_rs1, ex_rs2;
   logic       mem_valid, mem_Branch, mem_MemRead, mem_MemtoReg, mem_MemWrite, mem_ALUSrc, mem_RegWrite;
   logic [1:0] mem_ALUOp;
   logic [4:0] mem_rd;
   logic       wb_valid, wb_Branch, wb_MemRead, wb_MemtoReg, wb_MemWrite, wb_ALUSrc, wb_RegWrite;
   logic [1:0] wb_ALUOp;
   logic [4:0] wb_rd;
   logic [1:0] forward_a, forward_b;

   control_pipeline #(.REG_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
      .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
      .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
      .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
      .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .mem_valid(mem_valid), .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead),
      .mem_MemtoReg(mem_MemtoReg), .mem_MemWrite(mem_MemWrite), .mem_ALUSrc(mem_ALUSrc),
      .mem_RegWrite(mem_RegWrite), .mem_ALUOp(mem_ALUOp), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_Branch(wb_Branch), .wb_MemRead(wb_MemRead),
      .wb_MemtoReg(wb_MemtoReg), .wb_MemWrite(wb_MemWrite), .wb_ALUSrc(wb_ALUSrc),
      .wb_RegWrite(wb_RegWrite), .wb_ALUOp(wb_ALUOp), .wb_rd(wb_rd),
      .forward_a(forward_a), .forward_b(forward_b)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // hist[0] entered EX on the last edge, hist[1] the edge before (MEM), hist[2] (WB).
   ins_t hist[$];
   ins_t m_next;

   ins_t dut_ex, dut_mem, dut_wb;
   assign dut_ex  = {ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
                     ex_RegWrite, ex_ALUOp, ex_rd, ex_rs1, ex_rs2};
   assign dut_mem = {mem_valid, mem_Branch, mem_MemRead, mem_MemtoReg, mem_MemWrite, mem_ALUSrc,
                     mem_RegWrite, mem_ALUOp, mem_rd, 5'd0, 5'd0};
   assign dut_wb  = {wb_valid, wb_Branch, wb_MemRead, wb_MemtoReg, wb_MemWrite, wb_ALUSrc,
                     wb_RegWrite, wb_ALUOp, wb_rd, 5'd0, 5'd0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic v, br, mr, m2r, mw, as, rw, input logic [1:0] op,
                               input logic [4:0] rd, rs1, rs2);
      return {v, br, mr, m2r, mw, as, rw, op, rd, rs1, rs2};
   endfunction

   function automatic ins_t cur_id();
      ins_t x;
      x = '0;
      if (id_valid)
         x = mk(1'b1, id_Branch, id_MemRead, id_MemtoReg & id_RegWrite, id_MemWrite, id_ALUSrc,
                id_RegWrite, id_ALUOp, id_rd, id_rs1, id_rs2);
      return x;
   endfunction

   function automatic ins_t strip(input ins_t x);
      ins_t y;
      y = x;
      y.rs1 = 5'd0;
      y.rs2 = 5'd0;
      return y;
   endfunction

   function automatic logic exp_flush();
      return reset_n && hist[0].v && hist[0].br && ex_branch_taken;
   endfunction

   function automatic logic exp_stall();
      return reset_n && !exp_flush() && id_valid && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
             (hist[0].rd == id_rs1 || hist[0].rd == id_rs2);
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (!reset_n) return 2'b00;
      if (hist[1].v && hist[1].rw && hist[1].rd != 0 && hist[1].rd == rs) return 2'b10;
      if (hist[2].v && hist[2].rw && hist[2].rd != 0 && hist[2].rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   initial begin
      hist.push_back('0);
      hist.push_back('0);
      hist.push_back('0);
   end

   always @(posedge clk) begin
      if (!reset_n) begin
         m_next = '0;
         hist[0] = '0;
         hist[1] = '0;
         hist[2] = '0;
      end else begin
         m_next = (exp_stall() || exp_flush()) ? '0 : cur_id();
         hist.push_front(m_next);
         void'(hist.pop_back());
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("stall", 32'(stall), 32'(exp_stall()));
         chk("flush", 32'(flush), 32'(exp_flush()));
         chk("forward_a", 32'(forward_a), 32'(exp_fwd(hist[0].rs1)));
         chk("forward_b", 32'(forward_b), 32'(exp_fwd(hist[0].rs2)));
         chk("ex_stage",  32'(dut_ex),  32'(hist[0]));
         chk("mem_stage", 32'(dut_mem), 32'(strip(hist[1])));
         chk("wb_stage",  32'(dut_wb),  32'(strip(hist[2])));
      end
   end

   task automatic drive(input ins_t x, input logic bt);
      id_valid    = x.v;
      id_Branch   = x.br;
      id_MemRead  = x.mr;
      id_MemtoReg = x.m2r;
      id_MemWrite = x.mw;
      id_ALUSrc   = x.as;
      id_RegWrite = x.rw;
      id_ALUOp    = x.op;
      id_rd       = x.rd;
      id_rs1      = x.rs1;
      id_rs2      = x.rs2;
      ex_branch_taken = bt;
   endtask

   task automatic apply(input ins_t x, input logic bt);
      drive(x, bt);
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply('0, 1'b0);
         adv();
      end
   endtask

   localparam ins_t NOP = '0;

   ins_t load7, add_use7, x;
   bit   hold;

   initial begin
      reset_n = 1'b0;
      drive(NOP, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      apply(NOP, 1'b0);
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_wb_rd", 32'(wb_rd), 32'd0);
      reset_n = 1'b1;
      adv();

      // Straight-line R-type rd=5 followed by NOPs
      apply(mk(1,0,0,1,0,0,1, 2'b10, 5'd5, 5'd1, 5'd2), 1'b0);
      adv();
      chk("first_ex_valid", 32'(ex_valid), 32'd1);
      idle(2);
      apply(NOP, 1'b0);
      chk("straight_wb_RegWrite", 32'(wb_RegWrite), 32'd1);
      chk("straight_wb_rd", 32'(wb_rd), 32'd5);
      chk("straight_wb_ALUOp", 32'(wb_ALUOp), 32'd2);
      adv();
      idle(2);

      // Load-use: load rd=7 then add rs1=7
      load7    = mk(1,0,1,1,0,1,1, 2'b00, 5'd7, 5'd2, 5'd0);
      add_use7 = mk(1,0,0,0,0,0,1, 2'b10, 5'd8, 5'd7, 5'd1);
      apply(load7, 1'b0);
      chk("lu_no_stall_on_load", 32'(stall), 32'd0);
      adv();
      apply(add_use7, 1'b0);
      chk("lu_stall", 32'(stall), 32'd1);
      adv();
      apply(add_use7, 1'b0);
      chk("lu_stall_released", 32'(stall), 32'd0);
      chk("lu_ex_bubble", 32'(ex_valid), 32'd0);
      adv();
      apply(NOP, 1'b0);
      chk("lu_forward_a_wb", 32'(forward_a), 32'd1);
      adv();
      idle(3);

      // MEM forward, then the same pattern through r0
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd3, 5'd1, 5'd2), 1'b0);
      adv();
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd9, 5'd4, 5'd3), 1'b0);
      adv();
      apply(NOP, 1'b0);
      chk("memfwd_forward_b", 32'(forward_b), 32'd2);
      adv();
      idle(3);
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd0, 5'd1, 5'd2), 1'b0);
      adv();
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd9, 5'd4, 5'd0), 1'b0);
      adv();
      apply(NOP, 1'b0);
      chk("r0_forward_b", 32'(forward_b), 32'd0);
      adv();
      idle(3);

      // Double hazard: rd=4 in both MEM and WB
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd4, 5'd1, 5'd2), 1'b0);
      adv();
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd4, 5'd5, 5'd6), 1'b0);
      adv();
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd10, 5'd4, 5'd1), 1'b0);
      adv();
      apply(NOP, 1'b0);
      chk("double_forward_a", 32'(forward_a), 32'd2);
      adv();
      idle(3);

      // Flush: taken branch in EX with a load-use pattern against ID
      apply(mk(1,1,1,0,0,0,0, 2'b01, 5'd6, 5'd1, 5'd2), 1'b0);
      adv();
      apply(mk(1,0,0,0,0,0,1, 2'b10, 5'd11, 5'd6, 5'd1), 1'b1);
      chk("flush_flush", 32'(flush), 32'd1);
      chk("flush_stall", 32'(stall), 32'd0);
      adv();
      apply(NOP, 1'b0);
      chk("flush_ex_valid", 32'(ex_valid), 32'd0);
      adv();
      idle(3);

      // Reset for one cycle while a load-use stall is pending
      apply(load7, 1'b0);
      adv();
      apply(add_use7, 1'b0);
      chk("rst_pre_stall", 32'(stall), 32'd1);
      reset_n = 1'b0;
      adv();
      reset_n = 1'b1;
      apply(add_use7, 1'b0);
      chk("rst_stall_cleared", 32'(stall), 32'd0);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_ex_MemRead", 32'(ex_MemRead), 32'd0);
      adv();
      apply(NOP, 1'b0);
      chk("rst_first_capture", 32'(ex_valid), 32'd1);
      adv();
      idle(3);

      // Randomized traffic; upstream holds ID whenever the model predicts a stall
      hold = 1'b0;
      x = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!hold)
            x = mk(($urandom_range(9) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(3)),
                   5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
         reset_n = ($urandom_range(199) != 0);
         apply(x, 1'($urandom));
         hold = exp_stall();
         adv();
      end
      reset_n = 1'b1;
      idle(4);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
